// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between fetch and load/store,
// with combinational stall outputs and a watchdog that force-completes a stuck access.
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_ren,
  input  logic [31:0] i_imem_addr,
  output logic [31:0] o_imem_rdata,
  output logic        o_inst_busy,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_data_busy,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds ren/wen and its fields stable while its busy is high;
  // the memory sees o_mem_req held with stable fields until a one-cycle i_mem_ack.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              last_inst;
  logic [CNT_W-1:0]  cnt;
  logic              dreq, ireq, expire, done, d_done, i_done;
  logic              grant_d, grant_i;
  logic [31:0]       rd_val, dmem_rdata_q, imem_rdata_q;

  assign dreq   = i_dmem_ren | i_dmem_wen;
  assign ireq   = i_imem_ren;
  assign expire = (state != IDLE) && (cnt == CNT_W'(TIMEOUT - 1)) && !i_mem_ack;
  assign done   = (state != IDLE) && (i_mem_ack || expire) && !i_rst;
  assign d_done = done && (state == DATA);
  assign i_done = done && (state == INST);
  // A forced completion returns zero data.
  assign rd_val = i_mem_ack ? i_mem_rdata : 32'h0;

  always_comb begin
    state_nx = state;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && (!ireq || last_inst)) begin
          grant_d  = 1'b1;
          state_nx = DATA;
        end else if (ireq) begin
          grant_i  = 1'b1;
          state_nx = INST;
        end
      end
      DATA, INST: if (done) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      last_inst    <= 1'b1;
      cnt          <= '0;
      o_mem_wen    <= 1'b0;
      o_mem_addr   <= 32'h0;
      o_mem_wdata  <= 32'h0;
      o_mem_mask   <= 4'h0;
      dmem_rdata_q <= 32'h0;
      imem_rdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= ((state != IDLE) && !done) ? cnt + CNT_W'(1) : '0;
      if (grant_d) begin
        last_inst   <= 1'b0;
        o_mem_wen   <= i_dmem_wen;
        o_mem_addr  <= i_dmem_addr;
        o_mem_wdata <= i_dmem_wdata;
        o_mem_mask  <= i_dmem_mask;
      end
      if (grant_i) begin
        last_inst   <= 1'b1;
        o_mem_wen   <= 1'b0;
        o_mem_addr  <= i_imem_addr;
        o_mem_wdata <= 32'h0;
        o_mem_mask  <= 4'hF;
      end
      if (d_done && !o_mem_wen) dmem_rdata_q <= rd_val;
      if (i_done)               imem_rdata_q <= rd_val;
    end
  end

  assign o_mem_req    = (state != IDLE);
  assign o_err        = expire && !i_rst;
  assign o_dmem_rdata = (d_done && !o_mem_wen) ? rd_val : dmem_rdata_q;
  assign o_imem_rdata = i_done ? rd_val : imem_rdata_q;
  // Busy follows only the live request, so a flushed requester is never stalled.
  assign o_data_busy  = !i_rst && dreq && !d_done;
  assign o_inst_busy  = !i_rst && ireq && !i_done;
  assign dbg_state    = state;

endmodule
